// File: rtl/bit_serial_operand_feeder.sv
// rtl/bit_serial_operand_feeder.sv - operand feeder that clears, primes and streams a bit-serial adder
// Optional macro CARRY_CAPTURE_EN: capture the adder carry-out into carry_out at the last bit.
module bit_serial_operand_feeder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             ser_rst_n,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_cin,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_cout,
    output logic             done,
    output logic             carry_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CLR, PRIME, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_rst_n_q, ser_rst_n_d;
    logic             done_q, done_d;
    logic             carry_q, carry_d;
    logic             last_bit;

    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    cin_d   = in_cin;
                    state_d = CLR;
                end
            end
            CLR:   state_d = PRIME;
            PRIME: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef CARRY_CAPTURE_EN
                    carry_d = ser_cout;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        // The adder sees reset exactly during the CLR cycle, and during our own reset.
        ser_rst_n_d = (state_d != CLR);
    end

`ifndef CARRY_CAPTURE_EN
    logic unused_cout;
    assign unused_cout = ser_cout;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            cnt_q       <= '0;
            ser_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            cnt_q       <= cnt_d;
            ser_rst_n_q <= ser_rst_n_d;
            done_q      <= done_d;
            carry_q     <= carry_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign ser_rst_n = ser_rst_n_q;
    assign ser_a     = (state_q == SHIFT) & a_q[0];
    assign ser_b     = (state_q == SHIFT) & b_q[0];
    assign ser_cin   = (state_q == PRIME) & cin_q;
    assign ser_valid = (state_q == SHIFT);
    assign ser_last  = last_bit;
    assign done      = done_q;
    assign carry_out = carry_q;

endmodule
